jtkiwi_shr_sub: RTL and testbench



---
 rtl/jtkiwi_shr_sub.sv | 151 +++++++++++++++
 tb/tb_jtkiwi_shr_sub.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkiwi_shr_sub.sv
// Sub-CPU side of the Kiwi shared-RAM handshake: request, stall until granted, single access.
// Optional grant watchdog is compiled in with JTKIWI_SHR_TIMEOUT_EN.
module jtkiwi_shr_sub #(
    parameter logic [2:0]  WIN     = 3'b111,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        rst,
    input  logic        clk,
    input  logic [15:0] sub_addr,
    input  logic        sub_mreq_n,
    input  logic        sub_rfsh_n,
    input  logic        sub_rd_n,
    input  logic        sub_wr_n,
    input  logic [7:0]  sub_dout,
    output logic [7:0]  sub_din,
    output logic        sub_busy,
    output logic        shr_cs,
    output logic [12:0] shr_addr,
    output logic [7:0]  shr_din,
    output logic        sub_rnw,
    input  logic        shr_gnt,
    input  logic [7:0]  shr_dout,
    output logic [7:0]  st_dout
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_ACC  = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;

    logic [2:0]  state_q, state_d;
    logic        shr_cs_q, shr_cs_d;
    logic [12:0] shr_addr_q, shr_addr_d;
    logic [7:0]  shr_din_q, shr_din_d;
    logic        sub_rnw_q, sub_rnw_d;
    logic [7:0]  sub_din_q, sub_din_d;
    logic        timeout_flag_q, timeout_flag_d;
    logic        timeout_hit;
    logic        acc;

    assign acc = ~sub_mreq_n & sub_rfsh_n & (~sub_rd_n | ~sub_wr_n) & (sub_addr[15:13] == WIN);

`ifdef JTKIWI_SHR_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = 8'd0;
        end else if (state_q == ST_REQ) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Fires on the last REQ cycle allowed before giving up on the grant
    assign timeout_hit = (state_q == ST_REQ) && ((cnt_q + 8'd1) == TO_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        shr_cs_d       = shr_cs_q;
        shr_addr_d     = shr_addr_q;
        shr_din_d      = shr_din_q;
        sub_rnw_d      = sub_rnw_q;
        sub_din_d      = sub_din_q;
        timeout_flag_d = timeout_flag_q;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    shr_addr_d = sub_addr[12:0];
                    shr_din_d  = sub_dout;
                    sub_rnw_d  = sub_wr_n;
                    shr_cs_d   = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!acc) begin
                    shr_cs_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (shr_gnt) begin
                    state_d = ST_ACC;
                end else if (timeout_hit) begin
                    // Release the arbiter and hand the CPU a dummy value; any write is dropped
                    shr_cs_d       = 1'b0;
                    sub_din_d      = 8'hFF;
                    timeout_flag_d = 1'b1;
                    state_d        = ST_DONE;
                end
            end
            ST_ACC: begin
                sub_din_d = shr_dout;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                if (!acc) begin
                    shr_cs_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                shr_cs_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            shr_cs_q       <= 1'b0;
            shr_addr_q     <= 13'd0;
            shr_din_q      <= 8'd0;
            sub_rnw_q      <= 1'b1;
            sub_din_q      <= 8'd0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shr_cs_q       <= shr_cs_d;
            shr_addr_q     <= shr_addr_d;
            shr_din_q      <= shr_din_d;
            sub_rnw_q      <= sub_rnw_d;
            sub_din_q      <= sub_din_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign sub_busy = acc & ((state_q == ST_IDLE) | (state_q == ST_REQ) | (state_q == ST_ACC));
    assign shr_cs   = shr_cs_q;
    assign shr_addr = shr_addr_q;
    assign shr_din  = shr_din_q;
    assign sub_rnw  = sub_rnw_q;
    assign sub_din  = sub_din_q;
    assign st_dout  = {timeout_flag_q, 4'd0, state_q};

endmodule

// File: tb/tb_jtkiwi_shr_sub.sv
// Bench for jtkiwi_shr_sub: directed transaction table, corner sequences, random traffic vs model.
module tb_jtkiwi_shr_sub;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sub_addr = 16'd0;
    logic        sub_mreq_n = 1'b1;
    logic        sub_rfsh_n = 1'b1;
    logic        sub_rd_n = 1'b1;
    logic        sub_wr_n = 1'b1;
    logic [7:0]  sub_dout = 8'd0;
    logic [7:0]  sub_din;
    logic        sub_busy;
    logic        shr_cs;
    logic [12:0] shr_addr;
    logic [7:0]  shr_din;
    logic        sub_rnw;
    logic        shr_gnt = 1'b0;
    logic [7:0]  shr_dout = 8'd0;
    logic [7:0]  st_dout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jtkiwi_shr_sub #(
        .WIN     (3'b111),
        .TIMEOUT (TO)
    ) dut (
        .rst        (rst),
        .clk        (clk),
        .sub_addr   (sub_addr),
        .sub_mreq_n (sub_mreq_n),
        .sub_rfsh_n (sub_rfsh_n),
        .sub_rd_n   (sub_rd_n),
        .sub_wr_n   (sub_wr_n),
        .sub_dout   (sub_dout),
        .sub_din    (sub_din),
        .sub_busy   (sub_busy),
        .shr_cs     (shr_cs),
        .shr_addr   (shr_addr),
        .shr_din    (shr_din),
        .sub_rnw    (sub_rnw),
        .shr_gnt    (shr_gnt),
        .shr_dout   (shr_dout),
        .st_dout    (st_dout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level view of the handshake.
    // phase: 0 no transaction, 1 waiting for grant, 2 RAM owned (data cycle), 3 finished, CPU free
    int          m_phase = 0;
    int          m_wait  = 0;
    logic        m_cs    = 1'b0;
    logic [12:0] m_addr  = 13'd0;
    logic [7:0]  m_din   = 8'd0;
    logic        m_rnw   = 1'b1;
    logic [7:0]  m_sdin  = 8'd0;
    logic        m_flag  = 1'b0;

    function automatic logic acc_now();
        return !sub_mreq_n && sub_rfsh_n && (!sub_rd_n || !sub_wr_n) && (sub_addr >= 16'hE000);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_wait  <= 0;
            m_cs    <= 1'b0;
            m_addr  <= 13'd0;
            m_din   <= 8'd0;
            m_rnw   <= 1'b1;
            m_sdin  <= 8'd0;
            m_flag  <= 1'b0;
        end else begin
            case (m_phase)
                0: if (acc_now()) begin
                    m_addr  <= 13'(sub_addr % 16'h2000);
                    m_din   <= sub_dout;
                    m_rnw   <= sub_wr_n;
                    m_cs    <= 1'b1;
                    m_wait  <= 0;
                    m_phase <= 1;
                end
                1: if (!acc_now()) begin
                    m_cs    <= 1'b0;
                    m_phase <= 0;
                end else if (shr_gnt) begin
                    m_phase <= 2;
                end else begin
`ifdef JTKIWI_SHR_TIMEOUT_EN
                    if (m_wait + 1 == int'(TO)) begin
                        m_cs    <= 1'b0;
                        m_sdin  <= 8'hFF;
                        m_flag  <= 1'b1;
                        m_phase <= 3;
                    end
`endif
                    m_wait <= m_wait + 1;
                end
                2: begin
                    m_sdin  <= shr_dout;
                    m_phase <= 3;
                end
                default: if (!acc_now()) begin
                    m_cs    <= 1'b0;
                    m_phase <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("mon_busy", sub_busy, acc_now() && m_phase != 3);
        chk("mon_cs", shr_cs, m_cs);
        chk("mon_addr", shr_addr, m_addr);
        chk("mon_din", shr_din, m_din);
        chk("mon_rnw", sub_rnw, m_rnw);
        chk("mon_sub_din", sub_din, m_sdin);
        chk("mon_flag", st_dout[7], m_flag);
        chk("mon_pad", st_dout[6:3], 4'd0);
    end

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  wdata;
        int          d;       // REQ cycle (1-based) in which the grant first appears
        logic [7:0]  rdata;
        logic        exp_cs;
        int          exp_busy;
        logic [12:0] exp_addr;
        logic [7:0]  exp_din;
        logic        exp_rnw;
        logic [7:0]  exp_sub_din;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        sub_mreq_n = 1'b1;
        sub_rd_n   = 1'b1;
        sub_wr_n   = 1'b1;
        shr_gnt    = 1'b0;
    endtask

    task automatic start_acc(input logic [15:0] a, input logic wr, input logic [7:0] wd);
        sub_addr   = a;
        sub_dout   = wd;
        sub_rfsh_n = 1'b1;
        sub_mreq_n = 1'b0;
        sub_rd_n   = wr;
        sub_wr_n   = ~wr;
        shr_gnt    = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        int busy = 0;
        int cs = 0;
        int cyc = 0;
        logic done = 1'b0;
        tick();
        start_acc(v.addr, v.wr, v.wdata);
        shr_dout = v.rdata;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (sub_busy) busy++;
            if (shr_cs) begin
                cs++;
                chk("txn_addr", shr_addr, v.exp_addr);
                chk("txn_din", shr_din, v.exp_din);
                chk("txn_rnw", sub_rnw, v.exp_rnw);
            end
            if (!sub_busy) done = 1'b1;
            else shr_gnt = (v.d != 0) && (cs >= v.d);
        end
        chk("txn_done", done, 1'b1);
        chk("txn_busy_cycles", busy, v.exp_busy);
        chk("txn_sub_din", sub_din, v.exp_sub_din);
        chk("txn_cs_done", shr_cs, v.exp_cs);
        tick();
        idle_bus();
        @(negedge clk);
        chk("txn_cs_hold", shr_cs, v.exp_cs);
        @(negedge clk);
        chk("txn_cs_drop", shr_cs, 1'b0);
    endtask

    vec_t vecs[6];
    vec_t after_rst;

    initial begin
        int busy;
        vecs[0] = '{16'hE123, 1'b0, 8'h00, 1, 8'h5A, 1'b1, 3, 13'h0123, 8'h00, 1'b1, 8'h5A};
        vecs[1] = '{16'hFFFF, 1'b1, 8'h3C, 10, 8'h77, 1'b1, 12, 13'h1FFF, 8'h3C, 1'b0, 8'h77};
        vecs[2] = '{16'hC000, 1'b0, 8'h00, 1, 8'h12, 1'b0, 0, 13'h1FFF, 8'h3C, 1'b0, 8'h77};
        vecs[3] = '{16'hE000, 1'b0, 8'h11, 2, 8'hA5, 1'b1, 4, 13'h0000, 8'h11, 1'b1, 8'hA5};
        vecs[4] = '{16'hF800, 1'b1, 8'h81, 1, 8'hC3, 1'b1, 3, 13'h1800, 8'h81, 1'b0, 8'hC3};
        vecs[5] = '{16'h2000, 1'b1, 8'h55, 1, 8'h66, 1'b0, 0, 13'h1800, 8'h81, 1'b0, 8'hC3};
        after_rst = '{16'hE010, 1'b0, 8'h00, 1, 8'h3C, 1'b1, 3, 13'h0010, 8'h00, 1'b1, 8'h3C};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs", shr_cs, 1'b0);
        chk("rst_rnw", sub_rnw, 1'b1);
        chk("rst_addr", shr_addr, 13'd0);
        chk("rst_din", shr_din, 8'd0);
        chk("rst_sub_din", sub_din, 8'd0);
        chk("rst_flag", st_dout[7], 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Abort while waiting for the grant
        tick();
        start_acc(16'hE456, 1'b0, 8'h99);
        repeat (3) @(negedge clk);
        tick();
        idle_bus();
        @(negedge clk);
        chk("abort_cs_hold", shr_cs, 1'b1);
        @(negedge clk);
        chk("abort_cs", shr_cs, 1'b0);
        chk("abort_sub_din", sub_din, 8'hC3);

        // Reset in the data cycle
        tick();
        start_acc(16'hE010, 1'b0, 8'h00);
        shr_dout = 8'h3C;
        @(negedge clk);
        @(negedge clk);
        shr_gnt = 1'b1;
        tick();
        chk("acc_busy", sub_busy, 1'b1);
        chk("acc_cs", shr_cs, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_cs", shr_cs, 1'b0);
        chk("midrst_rnw", sub_rnw, 1'b1);
        chk("midrst_sub_din", sub_din, 8'h00);
        idle_bus();
        #1 rst = 1'b0;
        run_txn(after_rst);

        // Grant never arrives
        tick();
        start_acc(16'hE777, 1'b0, 8'h00);
        busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sub_busy) busy++;
        end
`ifdef JTKIWI_SHR_TIMEOUT_EN
        chk("to_busy_cycles", busy, int'(TO) + 1);
        chk("to_sub_din", sub_din, 8'hFF);
        chk("to_flag", st_dout[7], 1'b1);
        chk("to_cs", shr_cs, 1'b0);
`else
        chk("nogrant_busy_cycles", busy, 100);
        chk("nogrant_cs", shr_cs, 1'b1);
        chk("nogrant_flag", st_dout[7], 1'b0);
`endif
        tick();
        idle_bus();
        @(negedge clk);
        @(negedge clk);
        chk("nogrant_cs_drop", shr_cs, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(3) == 0) begin
                sub_addr   = 16'($urandom);
                if ($urandom_range(3) != 0) sub_addr[15:13] = 3'b111;
                sub_mreq_n = ($urandom_range(4) == 0);
                sub_rfsh_n = ($urandom_range(9) != 0);
                sub_rd_n   = $urandom_range(1) == 1;
                sub_wr_n   = ~sub_rd_n | ($urandom_range(5) == 0);
                sub_dout   = 8'($urandom);
            end
            shr_gnt  = ($urandom_range(2) == 0);
            shr_dout = 8'($urandom);
        end
        tick();
        idle_bus();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
